// File: rtl/cone_harness_pkg.sv
// Shared types and constants for the cone launch/capture harness.
package cone_harness_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StSettle,
        StSample,
        StEmit
    } state_e;

    // x^16 + x^14 + x^13 + x^11 + 1, x^16 term implied by the shift-out
    localparam logic [15:0] MISR_POLY = 16'h6801;
    localparam logic [15:0] MISR_SEED = 16'hFFFF;

    localparam int unsigned DEF_N_IN          = 43;
    localparam int unsigned DEF_SETTLE_CYCLES = 2;
    localparam int unsigned DEF_WORD_W        = 32;

endpackage

// File: rtl/cone_result_packer.sv
// Packs sampled cone results LSB-first into words and runs the output handshake.
// Optional signature MISR enabled by CONE_CAPTURE_MISR_EN.
module cone_result_packer
    import cone_harness_pkg::*;
#(
    parameter int unsigned WORD_W = DEF_WORD_W
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        sample,
    input  logic                        last,
    input  logic                        cone_out,
    input  logic                        out_ready,
    output logic                        out_valid,
    output logic [WORD_W-1:0]           out_word,
    output logic [$clog2(WORD_W+1)-1:0] out_bits,
    output logic                        word_full
`ifdef CONE_CAPTURE_MISR_EN
    ,
    output logic [15:0]                 sig
`endif
);

    localparam int unsigned IdxW  = $clog2(WORD_W);
    localparam int unsigned BitsW = $clog2(WORD_W + 1);

    logic [IdxW-1:0]   idx_q;
    logic [WORD_W-1:0] word_q;
    logic [BitsW-1:0]  bits_q;
    logic              valid_q;

    assign word_full = (idx_q == IdxW'(WORD_W - 1));
    assign out_word  = word_q;
    assign out_bits  = bits_q;
    assign out_valid = valid_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q   <= '0;
            word_q  <= '0;
            bits_q  <= '0;
            valid_q <= 1'b0;
        end else if (sample) begin
            word_q[idx_q] <= cone_out;
            if (word_full || last) begin
                // idx is left alone here and reloaded when the word is taken
                bits_q  <= BitsW'(idx_q) + BitsW'(1);
                valid_q <= 1'b1;
            end else begin
                idx_q <= idx_q + IdxW'(1);
            end
        end else if (valid_q && out_ready) begin
            valid_q <= 1'b0;
            idx_q   <= '0;
            word_q  <= '0;
        end
    end

`ifdef CONE_CAPTURE_MISR_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            sig <= MISR_SEED;
        end else if (sample) begin
            sig <= {sig[14:0], 1'b0} ^ (sig[15] ? MISR_POLY : 16'h0000) ^ {15'd0, cone_out};
        end
    end
`endif

endmodule

// File: rtl/cone_launch_capture.sv
// Launch/settle/sample harness around a combinational cone; results go to the packer.
// Build with CONE_CAPTURE_MISR_EN to add the 16-bit sig output.
module cone_launch_capture
    import cone_harness_pkg::*;
#(
    parameter int unsigned N_IN          = DEF_N_IN,
    parameter int unsigned SETTLE_CYCLES = DEF_SETTLE_CYCLES,
    parameter int unsigned WORD_W        = DEF_WORD_W
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [N_IN-1:0]             in_vec,
    input  logic                        in_last,
    output logic [N_IN-1:0]             cone_in,
    input  logic                        cone_out,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [WORD_W-1:0]           out_word,
    output logic [$clog2(WORD_W+1)-1:0] out_bits,
    output logic                        busy
`ifdef CONE_CAPTURE_MISR_EN
    ,
    output logic [15:0]                 sig
`endif
);

    localparam int unsigned CntW = $clog2(SETTLE_CYCLES + 1);

    state_e          state_q;
    logic [CntW-1:0] cnt_q;
    logic            last_q;
    logic            word_full;

    assign in_ready = (state_q == StIdle);
    assign busy     = (state_q != StIdle);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cone_in <= '0;
            cnt_q   <= '0;
            last_q  <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        cone_in <= in_vec;
                        last_q  <= in_last;
                        cnt_q   <= CntW'(SETTLE_CYCLES - 1);
                        state_q <= StSettle;
                    end
                end
                StSettle: begin
                    if (cnt_q == '0) begin
                        state_q <= StSample;
                    end else begin
                        cnt_q <= cnt_q - CntW'(1);
                    end
                end
                StSample: begin
                    state_q <= (word_full || last_q) ? StEmit : StIdle;
                end
                StEmit: begin
                    if (out_ready) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    cone_result_packer #(
        .WORD_W (WORD_W)
    ) u_packer (
        .clk       (clk),
        .rst       (rst),
        .sample    (state_q == StSample),
        .last      (last_q),
        .cone_out  (cone_out),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_word  (out_word),
        .out_bits  (out_bits),
        .word_full (word_full)
`ifdef CONE_CAPTURE_MISR_EN
        ,
        .sig       (sig)
`endif
    );

endmodule

// File: tb/tb_cone_launch_capture.sv
// Self-checking bench: parity cone with one cycle of delay, bit-queue reference model.
module tb_cone_launch_capture;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Default instance
    logic        in_valid = 1'b0, in_ready, in_last = 1'b0;
    logic [42:0] in_vec = '0, cone_in;
    logic        cone_out = 1'b0, out_valid, out_ready = 1'b0, busy;
    logic [31:0] out_word;
    logic [5:0]  out_bits;

    // SETTLE_CYCLES=1, WORD_W=8 instance
    logic        in_valid1 = 1'b0, in_ready1, in_last1 = 1'b0;
    logic [42:0] in_vec1 = '0, cone_in1;
    logic        cone_out1 = 1'b0, out_valid1, out_ready1 = 1'b0, busy1;
    logic [7:0]  out_word1;
    logic [3:0]  out_bits1;

`ifdef CONE_CAPTURE_MISR_EN
    logic [15:0] sig, sig1;
`endif

    cone_launch_capture dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_vec    (in_vec),
        .in_last   (in_last),
        .cone_in   (cone_in),
        .cone_out  (cone_out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_word  (out_word),
        .out_bits  (out_bits),
        .busy      (busy)
`ifdef CONE_CAPTURE_MISR_EN
        ,
        .sig       (sig)
`endif
    );

    cone_launch_capture #(
        .N_IN          (43),
        .SETTLE_CYCLES (1),
        .WORD_W        (8)
    ) dut1 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid1),
        .in_ready  (in_ready1),
        .in_vec    (in_vec1),
        .in_last   (in_last1),
        .cone_in   (cone_in1),
        .cone_out  (cone_out1),
        .out_valid (out_valid1),
        .out_ready (out_ready1),
        .out_word  (out_word1),
        .out_bits  (out_bits1),
        .busy      (busy1)
`ifdef CONE_CAPTURE_MISR_EN
        ,
        .sig       (sig1)
`endif
    );

    // Cone stand-in: parity of the inputs, visible one cycle after they change
    always @(posedge clk) begin
        cone_out  <= ^cone_in;
        cone_out1 <= ^cone_in1;
    end

    int          errors = 0;
    int          checks = 0;
    bit          mdl_q[$];
    logic [15:0] mdl_sig = 16'hFFFF;
    logic [42:0] last_vec = '0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [42:0] mkvec(input bit p);
        logic [42:0] v;
        v = 43'({$urandom(), $urandom()});
        if ((^v) != p) v[0] = ~v[0];
        return v;
    endfunction

    // Signature = running polynomial division of the sampled bit stream
    function automatic logic [15:0] misr_step(input logic [15:0] s, input bit b);
        logic [16:0] t;
        t = {s, 1'b0};
        if (t[16]) t = t ^ 17'h1_6801;
        return t[15:0] ^ {15'd0, b};
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        mdl_q.delete();
        mdl_sig = 16'hFFFF;
    endtask

    task automatic send0(input logic [42:0] v, input bit last);
        int n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("in_ready_wait", 64'(in_ready), 64'd1);
        in_valid = 1'b1;
        in_vec   = v;
        in_last  = last;
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        last_vec = v;
        mdl_q.push_back(^v);
    endtask

    task automatic collect0(input int stall);
        logic [31:0] w;
        int          nb;
        int          n = 0;
        w  = '0;
        nb = mdl_q.size();
        for (int i = 0; i < nb; i++) begin
            w[i]    = mdl_q[i];
            mdl_sig = misr_step(mdl_sig, mdl_q[i]);
        end
        mdl_q.delete();
        while (!out_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("out_valid_wait", 64'(out_valid), 64'd1);
        for (int s = 0; s < stall; s++) begin
            check("stall_word", 64'(out_word), 64'(w));
            check("stall_bits", 64'(out_bits), 64'(nb));
            check("stall_in_ready", 64'(in_ready), 64'd0);
            check("stall_cone_in", 64'(cone_in), 64'(last_vec));
            in_valid = 1'b1;
            in_vec   = ~last_vec;
            @(negedge clk);
        end
        in_valid = 1'b0;
        check("word", 64'(out_word), 64'(w));
        check("bits", 64'(out_bits), 64'(nb));
`ifdef CONE_CAPTURE_MISR_EN
        check("sig", 64'(sig), 64'(mdl_sig));
`endif
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("post_emit_valid", 64'(out_valid), 64'd0);
        check("post_emit_ready", 64'(in_ready), 64'd1);
        check("post_emit_busy", 64'(busy), 64'd0);
`ifdef CONE_CAPTURE_MISR_EN
        check("sig_persist", 64'(sig), 64'(mdl_sig));
`endif
    endtask

    initial begin
        int          n;
        int          early;
        int          len;
        int          t1[8];
        logic [7:0]  w1;
        logic [42:0] v;

        // Reset state
        do_reset();
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_cone_in", 64'(cone_in), 64'd0);
        check("rst_out_word", 64'(out_word), 64'd0);
        check("rst_out_bits", 64'(out_bits), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
`ifdef CONE_CAPTURE_MISR_EN
        check("rst_sig", 64'(sig), 64'hFFFF);
`endif

        // Single vector with flush; latency to out_valid
        send0(43'h1, 1'b1);
        check("launch_cone_in", 64'(cone_in), 64'h1);
        check("launch_busy", 64'(busy), 64'd1);
        check("launch_in_ready", 64'(in_ready), 64'd0);
        n = 1;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("emit_latency", 64'(n), 64'd4);
        collect0(0);

        // Full word of alternating results, no early emit
        early = 0;
        for (int i = 0; i < 32; i++) begin
            if (out_valid) early++;
            send0(mkvec(((i % 2) == 0)), 1'b0);
        end
        check("no_early_word", 64'(early), 64'd0);
        collect0(0);

        // Flush of 1,1,0,1,1 with 10 cycles of backpressure
        send0(mkvec(1'b1), 1'b0);
        send0(mkvec(1'b1), 1'b0);
        send0(mkvec(1'b0), 1'b0);
        send0(mkvec(1'b1), 1'b0);
        send0(mkvec(1'b1), 1'b1);
        collect0(10);

        // Reset with 3 bits buffered and a fourth vector settling
        for (int i = 0; i < 4; i++) send0(mkvec(1'($urandom())), 1'b0);
        do_reset();
        check("midrst_cone_in", 64'(cone_in), 64'd0);
        check("midrst_in_ready", 64'(in_ready), 64'd1);
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_out_word", 64'(out_word), 64'd0);
        send0(mkvec(1'b1), 1'b0);
        send0(mkvec(1'b0), 1'b1);
        collect0(0);

        // Random word lengths (including exactly WORD_W with last) and stalls
        for (int k = 0; k < 6; k++) begin
            len = (k == 2) ? 32 : int'($urandom_range(1, 12));
            for (int i = 0; i < len; i++) send0(mkvec(1'($urandom())), (i == len - 1));
            collect0(int'($urandom_range(0, 3)));
        end
        repeat (4) @(negedge clk);
        check("no_extra_word", 64'(out_valid), 64'd0);

        // SETTLE_CYCLES=1 instance: spacing of accepts and sampling of new vector
        w1 = '0;
        in_valid1 = 1'b1;
        for (int i = 0; i < 8; i++) begin
            n = 0;
            while (!in_ready1 && n < 20) begin
                @(negedge clk);
                n++;
            end
            t1[i] = cyc;
            v = mkvec(((i % 2) == 1));
            w1[i] = ^v;
            in_vec1  = v;
            in_last1 = (i == 7);
            @(negedge clk);
        end
        in_valid1 = 1'b0;
        in_last1  = 1'b0;
        for (int i = 1; i < 8; i++) check("s1_spacing", 64'(t1[i] - t1[i-1]), 64'd3);
        n = 0;
        while (!out_valid1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("s1_word", 64'(out_word1), 64'(w1));
        check("s1_bits", 64'(out_bits1), 64'd8);
        out_ready1 = 1'b1;
        @(negedge clk);
        out_ready1 = 1'b0;
        repeat (3) @(negedge clk);
        check("s1_single_word", 64'(out_valid1), 64'd0);
        check("s1_idle", 64'(busy1), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cone_launch_capture.md
Name: cone_launch_capture

Overview:
- Sequential harness stage wrapped around one of our flat ASAP7 combinational cones (43 primary inputs, 1 primary output).
- Upstream side: accepts test vectors over valid/ready and holds each one in a launch register that drives the cone inputs.
- Downstream side: samples the cone output after a fixed settle budget and packs the result bits LSB-first into words for a valid/ready consumer.
- Sits between the stimulus source and the cone on one side, and between the cone and the result sink on the other.

Parameters:
- N_IN, 43, cone input vector width.
- SETTLE_CYCLES, 2, cycles between launch and sample (legal range 1..15).
- WORD_W, 32, result bits per output word (legal range 2..64).

Ports:
- clk  in  1  single clock, all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  vector offered.
- in_ready  out  1  harness can accept a vector.
- in_vec  in  N_IN  stimulus vector.
- in_last  in  1  flush: emit the word after this vector even if not full.
- cone_in  out  N_IN  registered launch vector, wired to the cone inputs.
- cone_out  in  1  cone primary output.
- out_valid  out  1  result word available.
- out_ready  in  1  sink accepts the word.
- out_word  out  WORD_W  packed results; bit i is the i-th vector of the word.
- out_bits  out  $clog2(WORD_W+1)  number of valid bits in out_word (1..WORD_W).
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset:
  - State goes to IDLE.
  - cone_in=0, out_word=0, out_bits=0, out_valid=0, bit index=0, settle counter=0.
  - in_ready=1 from the first cycle after reset.
  - Reset mid-operation discards the in-flight vector and any partial word; no output is emitted.
- FSM states: IDLE, SETTLE, SAMPLE, EMIT.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready: load cone_in<=in_vec, latch in_last, load counter<=SETTLE_CYCLES-1, go to SETTLE.
- SETTLE:
  - in_ready=0; cone_in is held.
  - Decrement the counter each cycle; at 0 go to SAMPLE.
  - With SETTLE_CYCLES=1, exactly one SETTLE cycle occurs.
- SAMPLE:
  - out_word[idx]<=cone_out; idx<=idx+1.
  - If idx==WORD_W-1 or the latched last flag is set: out_bits<=idx+1, go to EMIT.
  - Otherwise go to IDLE.
  - The sample is taken SETTLE_CYCLES+1 edges after the acceptance edge.
- EMIT:
  - out_valid=1; out_word and out_bits are stable while out_valid&!out_ready.
  - On out_ready: out_valid<=0, idx<=0, out_word<=0, go to IDLE.
- Bits above out_bits-1 are always 0.
- Throughput: one vector per SETTLE_CYCLES+2 cycles, plus emit stall cycles.
- in_last on the WORD_W-th vector produces a single full word, not a word plus an empty word.
- in_valid asserted outside IDLE is ignored; the source must hold it.
- cone_in changes only on an acceptance edge or on reset.
- Counter width is $clog2(SETTLE_CYCLES+1); idx width is $clog2(WORD_W); both wrap only through explicit reload.

Optional Feature:
- Macro: CONE_CAPTURE_MISR_EN.
- Defined:
  - Adds output sig (16 bits), a MISR over all sampled bits.
  - Polynomial x^16+x^14+x^13+x^11+1, seed 16'hFFFF on reset.
  - Shifts once per SAMPLE state, XORing cone_out into bit 0.
  - sig is not cleared by EMIT.
- Undefined: no sig port and no MISR logic; all other behaviour is identical.

Decomposition:
- Package cone_harness_pkg holds:
  - state enum typedef (IDLE/SETTLE/SAMPLE/EMIT);
  - MISR polynomial and seed constants;
  - default N_IN/WORD_W/SETTLE_CYCLES localparams.
- One natural sub-module: cone_result_packer.
  - Contents: idx, out_word, out_bits, EMIT handshake, and the optional MISR.
  - Driven by a sample strobe plus a last flag from the launch/settle FSM in the top.

Test Plan:
- Reset then single vector:
  - Stimulus: in_vec=43'h1, in_last=1, cone model output 1, SETTLE_CYCLES=2.
  - Response: cone_in=43'h1 one edge after acceptance; out_valid at cycle 4 after acceptance; out_word=1, out_bits=1.
- Full word, WORD_W=32:
  - Stimulus: 32 vectors whose cone results alternate 1,0,1,0,…
  - Response: one word, out_word=32'h5555_5555, out_bits=32; no word emitted earlier.
- Flush plus backpressure:
  - Stimulus: 5 vectors with results 1,1,0,1,1, in_last on the 5th; out_ready low for 10 cycles.
  - Response: out_word=32'h1B, out_bits=5, both stable for all 10 cycles; in_ready=0 throughout.
- Reset mid-SETTLE:
  - Stimulus: assert rst while 3 bits are buffered.
  - Response: next word holds only post-reset bits; cone_in=0 after reset.
- Settle timing, SETTLE_CYCLES=1:
  - Stimulus: cone model output toggles 1 cycle after its input changes.
  - Response: sampled value reflects the new vector; accepts are spaced exactly 3 cycles.
- MISR (with CONE_CAPTURE_MISR_EN):
  - Stimulus: 16 all-zero samples from seed 16'hFFFF.
  - Response: sig equals the reference-model value; sig persists across EMIT.
